tmds_rx_channel: RTL
====================

Name: tmds_rx_channel

Overview:
- Receive-side counterpart of the HDMI transmit PHY; one instance per TMDS data channel.
- Takes the raw 10-bit parallel words from the channel's deserializer in the pixel clock domain and recovers word alignment by searching for TMDS control tokens.
- Once aligned, it decodes each TMDS word back to 8-bit pixel data or 2-bit control, plus DE.
- Feeds the receive-side video timing recovery and capture logic.

Parameters:
- LOCK_COUNT, 8: consecutive control-token windows required to declare lock.
- SEARCH_TIMEOUT, 2048: cycles spent at one bit offset before slipping to the next.
- LOSS_TIMEOUT, 4096: cycles without any control token while locked before lock is dropped.

Ports:
- clk_pixel  input  1  pixel clock (1x); the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- raw_word  input  10  deserialized word; bit 0 is the earliest bit on the wire.
- locked  output  1  alignment achieved; outputs are valid.
- bit_offset  output  4  current alignment offset, 0..9.
- de  output  1  1 = data period, 0 = control period.
- ctrl  output  2  decoded control bits {C1,C0}; meaningful when de=0.
- data  output  8  decoded pixel byte; meaningful when de=1.

Behaviour:
- **Clock and reset.** Single clock domain; every register updates on the rising edge of clk_pixel.
- **Reset values.** While rst=1 at an edge: state=SEARCH, bit_offset=0, all counters=0, prev_word=0, locked=0, de=0, ctrl=0, data=0. A reset mid-lock applies these values at that edge; no partial state is retained.
- **Window formation.**
  - Every cycle: prev_word <= raw_word.
  - stream[19:0] = {raw_word, prev_word}; window = stream[bit_offset+9 : bit_offset].
  - With bit_offset=0 the window is prev_word.
- **Token detect.** Combinational match of window against the four control tokens, written bit9..bit0:
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
  - Any other 10-bit value is a data word.
- **Data decode.**
  - If q[9]=1, q[7:0] is inverted first.
  - d[0]=q[0].
  - For i=1..7: d[i] = q[i]^q[i-1] when q[8]=1, else ~(q[i]^q[i-1]).
- **State machine** (states SEARCH, SLIP, LOCKED).
  - SEARCH:
    - run_cnt increments on a token window and clears on a non-token window.
    - search_tmr increments every cycle.
    - Token that brings run_cnt to LOCK_COUNT -> LOCKED.
    - Else if search_tmr = SEARCH_TIMEOUT-1 -> SLIP.
    - If both occur on the same cycle, LOCKED wins.
  - SLIP (exactly 1 cycle):
    - bit_offset <= (bit_offset==9) ? 0 : bit_offset+1.
    - run_cnt and search_tmr cleared.
    - -> SEARCH.
  - LOCKED:
    - loss_tmr clears on any token window and otherwise increments.
    - loss_tmr reaching LOSS_TIMEOUT-1 without a token -> SEARCH with run_cnt, search_tmr and loss_tmr cleared; bit_offset is kept, so re-lock at the same offset is fast.
    - Data words never cause loss by themselves.
- **Outputs.**
  - locked = (state==LOCKED), registered.
  - Each edge: if state==LOCKED, {de,ctrl,data} <= decode(window); otherwise {de,ctrl,data} <= 0.
  - The first decoded output appears on the edge after locked rises.
  - On a data word, ctrl holds its last control value.
  - On a control token, data=0.
- **Latency.** In LOCKED at bit_offset=0, a word presented on raw_word at edge N appears on de/ctrl/data after edge N+1. Latency is fixed and independent of offset.
- **Counter widths.** Each counter is $clog2(parameter)+1 bits and saturates at its terminal value; none wraps.

Test Plan:
- Reset, then an aligned repeating stream of 0x354 -> locked=1 after edge 9 (prev fill, 8 tokens), bit_offset=0; next cycle de=0, ctrl=00.
- Aligned stream alternating tokens 0x0AB/0x2AB, then data words 0x100 and 0x2FF -> ctrl 01/11 alternating, then de=1 with data=0x00, then data=0xFE.
- Valid token/data mix delayed by 3 bits (token boundary at raw_word bit 3) -> SLIP pulses at cycles 2047, 4096 and 6145 -> locked with bit_offset=3; decoded values match the unshifted source.
- While locked, feed LOSS_TIMEOUT consecutive non-token words -> locked falls after word 4096; de/data forced 0; bit_offset unchanged; restoring tokens re-locks within LOCK_COUNT+1 cycles.
- run_cnt reaches LOCK_COUNT on the same cycle that search_tmr hits SEARCH_TIMEOUT-1 -> LOCKED, bit_offset not incremented.
- Assert rst for 1 cycle mid-lock at bit_offset=5 -> next edge locked=0, bit_offset=0, de=ctrl=data=0; search restarts from offset 0.

Source files
------------

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: recovers TMDS word alignment from control tokens and
// decodes each aligned 10-bit word into DE, {C1,C0} and pixel data.
module tmds_rx_channel #(
   parameter int unsigned LOCK_COUNT     = 8,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned LOSS_TIMEOUT   = 4096
) (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic [9:0] raw_word,
   output logic       locked,
   output logic [3:0] bit_offset,
   output logic       de,
   output logic [1:0] ctrl,
   output logic [7:0] data
);

   localparam int unsigned RunW    = $clog2(LOCK_COUNT) + 1;
   localparam int unsigned SearchW = $clog2(SEARCH_TIMEOUT) + 1;
   localparam int unsigned LossW   = $clog2(LOSS_TIMEOUT) + 1;

   localparam logic [RunW-1:0]    RunMax     = RunW'(LOCK_COUNT);
   localparam logic [RunW-1:0]    RunLast    = RunW'(LOCK_COUNT - 1);
   localparam logic [SearchW-1:0] SearchLast = SearchW'(SEARCH_TIMEOUT - 1);
   localparam logic [LossW-1:0]   LossLast   = LossW'(LOSS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      StSearch,
      StSlip,
      StLocked
   } state_t;

   state_t             state_q;
   logic [9:0]         prev_word_q;
   logic [RunW-1:0]    run_cnt_q;
   logic [SearchW-1:0] search_tmr_q;
   logic [LossW-1:0]   loss_tmr_q;

   logic [19:0] stream;
   logic [9:0]  window;
   logic        is_token;
   logic [1:0]  tok_ctrl;
   logic [7:0]  q_inv;
   logic [7:0]  dec_data;

   // Two-word stream, bit 0 earliest; the window slides up by bit_offset.
   assign stream = {raw_word, prev_word_q};
   assign window = 10'(stream >> bit_offset);

   // Match the window against the four control tokens.
   always_comb begin
      is_token = 1'b1;
      tok_ctrl = 2'b00;
      case (window)
         10'b1101010100: tok_ctrl = 2'b00;
         10'b0010101011: tok_ctrl = 2'b01;
         10'b0101010100: tok_ctrl = 2'b10;
         10'b1010101011: tok_ctrl = 2'b11;
         default:        is_token = 1'b0;
      endcase
   end

   // Undo the TMDS transition-minimising encode for a data word.
   always_comb begin
      q_inv    = window[9] ? ~window[7:0] : window[7:0];
      dec_data = '0;
      dec_data[0] = q_inv[0];
      for (int i = 1; i < 8; i++) begin
         dec_data[i] = window[8] ? (q_inv[i] ^ q_inv[i-1]) : ~(q_inv[i] ^ q_inv[i-1]);
      end
   end

   // Alignment FSM, counters and registered decode outputs.
   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         state_q      <= StSearch;
         prev_word_q  <= '0;
         run_cnt_q    <= '0;
         search_tmr_q <= '0;
         loss_tmr_q   <= '0;
         bit_offset   <= '0;
         locked       <= 1'b0;
         de           <= 1'b0;
         ctrl         <= 2'b00;
         data         <= 8'h00;
      end else begin
         prev_word_q <= raw_word;

         // Decode only while locked; ctrl keeps its last token value over data.
         if (state_q == StLocked) begin
            de <= ~is_token;
            if (is_token) begin
               ctrl <= tok_ctrl;
               data <= 8'h00;
            end else begin
               data <= dec_data;
            end
         end else begin
            de   <= 1'b0;
            ctrl <= 2'b00;
            data <= 8'h00;
         end

         case (state_q)
            StSearch: begin
               if (search_tmr_q != SearchLast) begin
                  search_tmr_q <= search_tmr_q + 1'b1;
               end
               if (is_token) begin
                  if (run_cnt_q != RunMax) begin
                     run_cnt_q <= run_cnt_q + 1'b1;
                  end
               end else begin
                  run_cnt_q <= '0;
               end
               // Lock takes priority over a timeout landing on the same cycle.
               if (is_token && (run_cnt_q == RunLast)) begin
                  state_q    <= StLocked;
                  locked     <= 1'b1;
                  loss_tmr_q <= '0;
               end else if (search_tmr_q == SearchLast) begin
                  state_q <= StSlip;
               end
            end

            StSlip: begin
               bit_offset   <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
               run_cnt_q    <= '0;
               search_tmr_q <= '0;
               state_q      <= StSearch;
            end

            StLocked: begin
               if (is_token) begin
                  loss_tmr_q <= '0;
               end else if (loss_tmr_q == LossLast) begin
                  // Keep bit_offset so a returning stream re-locks quickly.
                  state_q      <= StSearch;
                  locked       <= 1'b0;
                  run_cnt_q    <= '0;
                  search_tmr_q <= '0;
                  loss_tmr_q   <= '0;
               end else begin
                  loss_tmr_q <= loss_tmr_q + 1'b1;
               end
            end

            default: begin
               state_q <= StSearch;
               locked  <= 1'b0;
            end
         endcase
      end
   end

endmodule
